// File: rtl/sseg_pkg.sv
// Shared definitions for the push-button counter and the seven-segment display path.
// Segment patterns are active low, bit order {dp,g,f,e,d,c,b,a}.
package sseg_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [7:0]  SSEG_BLANK = 8'hFF;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ZERO,
    WAIT1,
    ONE,
    WAIT0
  } db_state_e;

  // Entry 0 is the rightmost element.
  localparam logic [9:0][7:0] SSEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] sseg_encode(input bcd_digit_t d);
    logic [7:0] pat;
    pat = SSEG_BLANK;
    if (d < 4'd10) pat = SSEG_TABLE[d];
    return pat;
  endfunction

endpackage

// File: rtl/debounce_fsm.sv
// Two-flop synchroniser, free-running tick prescaler and debounce state machine.
// A level change is accepted only after the input has stayed stable for DB_TICKS ticks.
module debounce_fsm
  import sseg_pkg::*;
#(
  parameter int unsigned TICK_N   = 19,
  parameter int unsigned DB_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic db_level,
  output logic db_tick
);

  localparam logic [2:0] STABLE_LOAD = 3'(DB_TICKS - 1);

  logic [1:0]        sync_q;
  logic              btn_s;
  logic [TICK_N-1:0] tick_cnt_q;
  logic              tick;
  db_state_e         state_q, state_d;
  logic [2:0]        stable_q, stable_d;
  logic              db_tick_q, db_tick_d;

  assign btn_s = sync_q[1];
  assign tick  = &tick_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      tick_cnt_q <= '0;
    end else begin
      sync_q     <= {sync_q[0], btn_raw};
      tick_cnt_q <= tick_cnt_q + TICK_N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ZERO;
      stable_q  <= '0;
      db_tick_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      db_tick_q <= db_tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    db_tick_d = 1'b0;
    unique case (state_q)
      ZERO: begin
        if (btn_s) begin
          state_d  = WAIT1;
          stable_d = STABLE_LOAD;
        end
      end
      WAIT1: begin
        if (!btn_s) begin
          state_d = ZERO;
        end else if (tick) begin
          if (stable_q == '0) begin
            state_d   = ONE;
            db_tick_d = 1'b1;
          end else begin
            stable_d = stable_q - 3'd1;
          end
        end
      end
      ONE: begin
        if (!btn_s) begin
          state_d  = WAIT0;
          stable_d = STABLE_LOAD;
        end
      end
      WAIT0: begin
        if (btn_s) begin
          state_d = ONE;
        end else if (tick) begin
          if (stable_q == '0) state_d = ZERO;
          else                stable_d = stable_q - 3'd1;
        end
      end
    endcase
  end

  always_comb begin
    db_level = (state_q == ONE) || (state_q == WAIT0);
    db_tick  = db_tick_q;
  end

endmodule

// File: rtl/press_count_sseg.sv
// Debounced press counter: 4-digit BCD count with registered active-low segment patterns
// feeding the display multiplexer; optional leading-zero blanking on digits 3..1.
module press_count_sseg
  import sseg_pkg::*;
#(
  parameter int unsigned TICK_N   = 19,
  parameter int unsigned DB_TICKS = 3,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_raw,
  input  logic        clr,
  output logic        db_level,
  output logic        db_tick,
  output logic [15:0] count,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3
);

  localparam logic [7:0] SEG_RST_HI = LZ_BLANK ? SSEG_BLANK : SSEG_TABLE[0];

  logic [15:0]      count_q, count_d;
  logic             carry;
  logic [3:0][7:0]  seg_q, seg_d;
  logic             hi_zero;
  bcd_digit_t       dig;

  debounce_fsm #(
    .TICK_N  (TICK_N),
    .DB_TICKS(DB_TICKS)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .db_level(db_level),
    .db_tick (db_tick)
  );

  always_comb begin
    count_d = count_q;
    carry   = 1'b1;
    if (clr) begin
      count_d = '0;
    end else if (db_tick) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (count_q[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
            count_d[i*DIGIT_W +: DIGIT_W] = '0;
          end else begin
            count_d[i*DIGIT_W +: DIGIT_W] = count_q[i*DIGIT_W +: DIGIT_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Walk from the most significant digit so hi_zero means "this and all higher digits are 0".
  always_comb begin
    seg_d   = '1;
    hi_zero = 1'b1;
    dig     = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      dig     = count_q[(3-j)*DIGIT_W +: DIGIT_W];
      hi_zero = hi_zero && (dig == '0);
      if (LZ_BLANK && hi_zero && (j != 3)) seg_d[3-j] = SSEG_BLANK;
      else                                 seg_d[3-j] = sseg_encode(dig);
    end
    seg_d[0][7] = ~db_level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      seg_q   <= {SEG_RST_HI, SEG_RST_HI, SEG_RST_HI, SSEG_TABLE[0]};
    end else begin
      count_q <= count_d;
      seg_q   <= seg_d;
    end
  end

  assign count = count_q;
  assign seg0  = seg_q[0];
  assign seg1  = seg_q[1];
  assign seg2  = seg_q[2];
  assign seg3  = seg_q[3];

endmodule

// File: doc/press_count_sseg.md
Name: press_count_sseg

Overview:
Upstream feeder for the 4-digit seven-segment multiplexer.
- Synchronises and debounces one raw push-button.
- Counts debounced presses in a 4-digit BCD counter (0000-9999, wraps).
- Presents each digit as a registered, active-low 8-bit segment pattern on seg0..seg3, which connect directly to the multiplexer's in0..in3.

Parameters:
TICK_N, 19, width of the free-running tick counter; tick period = 2^TICK_N clk cycles (~10.5 ms at 50 MHz).
DB_TICKS, 3, number of consecutive ticks the synchronised input must stay stable before a level change is accepted (1..7).
LZ_BLANK, 1, 1 = blank leading zeros on digits 3..1; digit 0 is never blanked.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_raw  in  1  asynchronous raw button, active high
clr  in  1  synchronous clear of the press count, active high, level
db_level  out  1  debounced button level
db_tick  out  1  one-cycle pulse on each accepted press (0->1 debounced edge)
count  out  16  BCD press count; [3:0] = digit 0 (least significant)
seg0  out  8  digit 0 pattern {dp,g,f,e,d,c,b,a}, active low
seg1  out  8  digit 1 pattern
seg2  out  8  digit 2 pattern
seg3  out  8  digit 3 pattern

Behaviour:
Clock and reset
- All clocked on clk rising edge; reset is synchronous, active-high.
- Reset has priority over every other input.

Synchroniser
- btn_raw passes through 2 flops to give btn_s; both flops reset to 0.

Tick generator
- Free-running TICK_N-bit counter; reset to 0.
- tick = 1 for one cycle whenever the counter is all ones.

Debounce FSM (states ZERO, WAIT1, ONE, WAIT0; reset -> ZERO)
- ZERO: if btn_s=1, go to WAIT1 and load stable_cnt = DB_TICKS-1.
- WAIT1:
  - btn_s=0 in any cycle -> ZERO.
  - Otherwise, on tick: if stable_cnt=0, go to ONE and assert db_tick; else decrement stable_cnt.
- ONE: if btn_s=0, go to WAIT0 and load stable_cnt = DB_TICKS-1.
- WAIT0: mirror of WAIT1 with polarity inverted; exit to ONE on btn_s=1; completes to ZERO.
- Release produces no pulse.
- db_level = 1 in states ONE and WAIT0; registered/decoded from state.
- db_tick is registered: high for exactly one cycle, the cycle after the WAIT1->ONE transition.
- Acceptance delay after btn_s rises: between (DB_TICKS-1)*2^TICK_N+1 and DB_TICKS*2^TICK_N cycles.

BCD counter
- 4 digits; reset to 0x0000.
- clr=1 -> 0x0000; clr has priority over a simultaneous db_tick.
- db_tick=1 -> increment with decimal carry: digit 9 -> 0 and carries into the next digit.
- 9999 + 1 -> 0000; no overflow flag.

Segment encode
- Registered; seg outputs reflect count one cycle after count changes.
- Active low, {dp,g,f,e,d,c,b,a} = 0..9 -> C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
- Leading-zero blank (LZ_BLANK=1): digit k (k=3..1) outputs FF when it and every higher digit are 0.
- dp of seg0 is driven low (lit) while db_level=1; all other dp bits are 1.

Reset values
- db_level=0, db_tick=0, count=0000, seg0=C0.
- seg1..seg3 = FF if LZ_BLANK, else C0.

Reset mid-operation
- Reset in WAIT1 or WAIT0 returns to ZERO; no db_tick is emitted.
- Tick counter restarts at 0.

BCD digit values
- Never A-F; increment logic only ever produces valid BCD.

Decomposition:
Shared package (sseg_pkg)
- Debounce state enum.
- SSEG_BLANK = 8'hFF.
- Digit-to-pattern constant table (10 entries).
- Digit width = 4.
- The disp_mux side uses the same package for the blank pattern.

Sub-module: debounce_fsm
- Contents: synchroniser, tick counter, FSM.
- Ports: clk, reset, btn_raw -> db_level, db_tick.
- Params: TICK_N, DB_TICKS.
- The top level holds the BCD counter and the segment encode.

Test Plan:
All scenarios run with TICK_N=3, DB_TICKS=3 (tick every 8 cycles); acceptance window 17-24 cycles.
- Bounce rejection: btn_raw toggles every 5 cycles for 60 cycles, then stays 0 -> db_tick never asserts; count=0000; seg0=C0; seg1..3=FF.
- Clean press: btn_raw=1 held for 40 cycles -> exactly one db_tick, 17-24 cycles after btn_s rises; count=0001; seg0=F9 one cycle later; seg0 dp bit low while db_level=1; releasing gives no second tick.
- Carry and blanking: 10 clean presses -> count=0010; seg1=F9, seg0=C0, seg2=seg3=FF. 100 presses -> seg2=F9, seg1=C0.
- Wrap: 10000 presses -> count=0000 after the press that follows 9999; seg0=C0; seg1..3=FF.
- Clear priority: assert clr in the same cycle as db_tick with count=0042 -> count=0000 next cycle, not 0001.
- Reset mid-debounce: btn_raw=1, assert reset while the FSM is in WAIT1, then deassert -> state ZERO; db_tick stays 0 through the reset cycle; count unchanged at 0000; the press is re-qualified from scratch, giving db_tick 17-24 cycles after btn_s rises again.
